// File: rtl/immediate_extender_if.sv
// Immediate extender bus: raw immediate in, extended value out.
// Master drives the instruction fields; slave is the extender.
interface immediate_extender_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic [IN_W-1:0]  in;
  logic             op;
  logic             load;
  logic             shift;
  logic [OUT_W-1:0] out;
  logic [OUT_W-1:0] out_q;
  logic             valid;

  modport master (
    output in, op, load, shift,
    input  out, out_q, valid
  );

  modport slave (
    input  in, op, load, shift,
    output out, out_q, valid
  );
endinterface

// File: rtl/immediate_extender.sv
// Zero/sign extends the instruction immediate, with a registered copy.
// Optional IMMEXT_SHIFT_EN enables the word-aligned <<2 on shift=1.
module immediate_extender #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  immediate_extender_if.slave   bus
);

  logic             fill;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] res;

  assign fill = bus.op & bus.in[IN_W-1];
  assign ext  = {{(OUT_W-IN_W){fill}}, bus.in};

`ifdef IMMEXT_SHIFT_EN
  // Top two extended bits fall off; width stays OUT_W.
  assign res = bus.shift ? {ext[OUT_W-3:0], 2'b00} : ext;
`else
  logic unused_shift;
  assign unused_shift = bus.shift;
  assign res = ext;
`endif

  assign bus.out = res;

  logic [OUT_W-1:0] out_q;
  logic             valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      valid <= 1'b0;
    end else if (bus.load) begin
      out_q <= res;
      valid <= 1'b1;
    end
  end

  assign bus.out_q = out_q;
  assign bus.valid = valid;

endmodule

// File: tb/tb_immediate_extender.sv
// Directed table-driven bench for immediate_extender.
// Shift expectations follow IMMEXT_SHIFT_EN.
module tb_immediate_extender;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  immediate_extender_if #(.IN_W(16), .OUT_W(32)) bus ();

  immediate_extender #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef IMMEXT_SHIFT_EN
  localparam bit SH_EN = 1'b1;
`else
  localparam bit SH_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] in;
    logic        op;
    logic        shift;
    logic [31:0] exp_plain;
    logic [31:0] exp_shift;
  } vec_t;

  vec_t vecs [10];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{"beef_zx",   16'hBEEF, 1'b0, 1'b0, 32'h0000BEEF, 32'h0000BEEF};
    vecs[1] = '{"beef_sx",   16'hBEEF, 1'b1, 1'b0, 32'hFFFFBEEF, 32'hFFFFBEEF};
    vecs[2] = '{"7fff_sx",   16'h7FFF, 1'b1, 1'b0, 32'h00007FFF, 32'h00007FFF};
    vecs[3] = '{"8000_sx",   16'h8000, 1'b1, 1'b0, 32'hFFFF8000, 32'hFFFF8000};
    vecs[4] = '{"0000_sx",   16'h0000, 1'b1, 1'b0, 32'h00000000, 32'h00000000};
    vecs[5] = '{"7fff_zx",   16'h7FFF, 1'b0, 1'b0, 32'h00007FFF, 32'h00007FFF};
    vecs[6] = '{"8000_zx",   16'h8000, 1'b0, 1'b0, 32'h00008000, 32'h00008000};
    vecs[7] = '{"0001_sx",   16'h0001, 1'b1, 1'b0, 32'h00000001, 32'h00000001};
    vecs[8] = '{"ffff_sx_sh", 16'hFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC};
    vecs[9] = '{"4000_zx_sh", 16'h4000, 1'b0, 1'b1, 32'h00004000, 32'h00010000};

    bus.in = 16'h1234;
    bus.op = 1'b0;
    bus.load = 1'b0;
    bus.shift = 1'b0;

    // Reset held with load toggling: register must stay cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.load = ~bus.load;
      bus.in = 16'hBEEF;
      @(posedge clk);
      #1;
      chk("rst_out_q", bus.out_q, 32'h0);
      chk("rst_valid", {31'b0, bus.valid}, 32'h0);
    end

    @(negedge clk);
    bus.load = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_valid", {31'b0, bus.valid}, 32'h0);
    chk("idle_out_q", bus.out_q, 32'h0);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] exp;
      @(negedge clk);
      exp = SH_EN ? vecs[i].exp_shift : vecs[i].exp_plain;
      bus.in = vecs[i].in;
      bus.op = vecs[i].op;
      bus.shift = vecs[i].shift;
      bus.load = 1'b1;
      #1;
      chk({vecs[i].name, "_out"}, bus.out, exp);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_out_q"}, bus.out_q, exp);
      chk({vecs[i].name, "_valid"}, {31'b0, bus.valid}, 32'h1);
    end

    // Capture then change inputs with load low: out_q must hold.
    @(negedge clk);
    bus.in = 16'hBEEF;
    bus.op = 1'b1;
    bus.shift = 1'b0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.in = 16'h1234;
    bus.op = 1'b0;
    bus.load = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_out", bus.out, 32'h00001234);
    chk("hold_out_q", bus.out_q, 32'hFFFFBEEF);
    chk("hold_valid", {31'b0, bus.valid}, 32'h1);
    @(posedge clk);
    #1;
    chk("hold2_out_q", bus.out_q, 32'hFFFFBEEF);

    // Reset falls while load is high: clears asynchronously.
    @(negedge clk);
    bus.in = 16'h5555;
    bus.load = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_q", bus.out_q, 32'h0);
    chk("arst_valid", {31'b0, bus.valid}, 32'h0);
    chk("arst_out", bus.out, 32'h00005555);
    @(posedge clk);
    #1;
    chk("arst_edge_out_q", bus.out_q, 32'h0);
    chk("arst_edge_valid", {31'b0, bus.valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
